// File: rtl/uart_nibble_tx.sv
// uart_nibble_tx: UART transmitter for nibble frames.
// Each frame is a start bit (0), then DATA_BITS data bits LSB first, then
// STOP_BITS stop bits (1). Every bit lasts CLK_FREQ_HZ/BAUD_RATE clocks.
// Words are queued through a valid/ready port into a FIFO. While the FIFO
// holds data, frames are sent back-to-back with no idle gap.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   in_data     nibble to transmit
//   in_valid    in_data valid
//   in_ready    FIFO has room; a push happens when in_valid && in_ready
//   tx          serial line, idle high, registered
//   busy        a frame is on the line
//   bit_strobe  one-cycle pulse in the first cycle of every bit
//   frame_done  one-cycle pulse in the last cycle of the final stop bit
//   fifo_count  current FIFO occupancy
module uart_nibble_tx #(
  parameter int CLK_FREQ_HZ = 1_600_000,
  parameter int BAUD_RATE   = 100_000,
  parameter int DATA_BITS   = 4,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          bit_strobe,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int BCW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cyc_q;
  logic [BCW-1:0]         bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [CNTW-1:0]        count_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   strobe_q;
  logic                   done_q;

  logic fifo_empty;
  logic bit_end;
  logic last_data;
  logic last_stop;
  logic frame_end;
  logic push;
  logic pop;

  assign in_ready   = (count_q < CNTW'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign bit_strobe = strobe_q;
  assign frame_done = done_q;

  always_comb begin
    fifo_empty = (count_q == '0);
    bit_end    = (cyc_q == CW'(CLKS_PER_BIT - 1));
    last_data  = (bit_q == BCW'(DATA_BITS - 1));
    last_stop  = (bit_q == BCW'(STOP_BITS - 1));
    frame_end  = (state_q == STOP) && bit_end && last_stop;
    push       = in_valid && in_ready;
    // Head is taken either from IDLE or at the very end of a stop bit, so a
    // queued word starts immediately after the previous frame.
    pop        = !fifo_empty && ((state_q == IDLE) || frame_end);
  end

  // FIFO storage: data only, written at the push edge.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Shift register: loaded on pop, shifted at each data-bit boundary.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= mem_q[rd_ptr_q];
    end else if ((state_q == DATA) && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Frame FSM. The line outputs are registered from the current state, so
  // they trail the state by one clock; that gives the two-edge push-to-start
  // latency and keeps tx, busy, bit_strobe and frame_done aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tx_q     <= 1'b1;
      busy_q   <= (state_q != IDLE);
      strobe_q <= (state_q != IDLE) && (cyc_q == '0);
      done_q   <= frame_end;
      cyc_q    <= bit_end ? '0 : cyc_q + CW'(1);
      case (state_q)
        IDLE: begin
          cyc_q <= '0;
          bit_q <= '0;
          if (!fifo_empty) state_q <= START;
        end
        START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (bit_end) begin
            if (last_data) begin
              bit_q   <= '0;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + BCW'(1);
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              bit_q   <= '0;
              state_q <= fifo_empty ? IDLE : START;
            end else begin
              bit_q <= bit_q + BCW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_nibble_tx.sv
module tb_uart_nibble_tx;

  localparam int CPB = 16;
  localparam int FL1 = 6 * CPB;
  localparam int FL2 = 7 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       bit_strobe;
  logic       frame_done;
  logic [2:0] fifo_count;

  logic [3:0] in_data2 = 4'h0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic       tx2;
  logic       busy2;
  logic       bit_strobe2;
  logic       frame_done2;
  logic [2:0] fifo_count2;

  int vectors = 0;
  int errors  = 0;
  logic [3:0] words [16];

  always #5 clk = ~clk;

  uart_nibble_tx dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .bit_strobe(bit_strobe),
    .frame_done(frame_done), .fifo_count(fifo_count)
  );

  uart_nibble_tx #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .bit_strobe(bit_strobe2),
    .frame_done(frame_done2), .fifo_count(fifo_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0d: observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Line level at offset t inside a frame of length fl carrying word w.
  function automatic logic exp_tx(input int t, input int fl, input logic [3:0] w);
    int b;
    b = (t % fl) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 4) return w[b-1];
    return 1'b1;
  endfunction

  // Words popped by edge e (e=0 is the first push into an idle, empty FIFO),
  // assuming the FIFO never runs dry before all n words are pushed.
  function automatic int pops(input int e, input int n, input int fl);
    int p;
    if (e < 1) return 0;
    p = 1 + (e - 1) / fl;
    return (p > n) ? n : p;
  endfunction

  task automatic check_line(input int t, input int n);
    if (t >= 0 && t < n * FL1) begin
      check("tx", t, tx, exp_tx(t, FL1, words[t / FL1]));
      check("busy", t, busy, 1);
      check("bit_strobe", t, bit_strobe, (t % CPB) == 0);
      check("frame_done", t, frame_done, (t % FL1) == FL1 - 1);
    end else begin
      check("tx_idle", t, tx, 1);
      check("busy_idle", t, busy, 0);
      check("bit_strobe_idle", t, bit_strobe, 0);
      check("frame_done_idle", t, frame_done, 0);
    end
  endtask

  // Push words[0..n-1] with in_valid held high, checking occupancy,
  // backpressure and the serial line every cycle.
  task automatic run_stream(input int n);
    int   pushed;
    logic rdy_exp;
    pushed = 0;
    for (int e = 0; e <= n * FL1 + 4; e++) begin
      rdy_exp  = (pushed - pops(e - 1, n, FL1)) < 4;
      in_valid = (pushed < n);
      in_data  = (pushed < n) ? words[pushed] : 4'($urandom);
      tick();
      if (in_valid && rdy_exp) pushed++;
      check("fifo_count", e, fifo_count, pushed - pops(e, n, FL1));
      check("in_ready", e, in_ready, (pushed - pops(e, n, FL1)) < 4);
      check_line(e - 2, n);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with in_valid asserted: nothing may be pushed.
    in_valid = 1'b1;
    in_data  = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", i, tx, 1);
      check("rst_busy", i, busy, 0);
      check("rst_in_ready", i, in_ready, 1);
      check("rst_fifo_count", i, fifo_count, 0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_fifo_count", 0, fifo_count, 0);
    check("post_rst_tx", 0, tx, 1);

    // Single frame 4'b0110.
    words[0] = 4'b0110;
    run_stream(1);

    // Back-to-back with backpressure, fixed list.
    words[0] = 4'h1; words[1] = 4'h0; words[2] = 4'h0; words[3] = 4'h4;
    words[4] = 4'h1; words[5] = 4'h9; words[6] = 4'h1; words[7] = 4'h4;
    words[8] = 4'h3; words[9] = 4'h6;
    run_stream(10);

    // Back-to-back, random words.
    for (int i = 0; i < 10; i++) words[i] = 4'($urandom);
    run_stream(10);

    // Mid-frame reset during data bit 2 with two words queued.
    words[0] = 4'b1001;
    words[1] = 4'($urandom);
    words[2] = 4'($urandom);
    begin
      int pushed;
      pushed = 0;
      for (int e = 0; e <= 52; e++) begin
        in_valid = (pushed < 3);
        in_data  = (pushed < 3) ? words[pushed] : 4'($urandom);
        tick();
        if (in_valid) pushed++;
        check_line(e - 2, 1);
      end
      in_valid = 1'b0;
      check("mid_fifo_count", 52, fifo_count, 2);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", 0, tx, 1);
      check("mid_rst_busy", 0, busy, 0);
      check("mid_rst_fifo_count", 0, fifo_count, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 150; i++) begin
        tick();
        check("after_rst_tx", i, tx, 1);
        check("after_rst_busy", i, busy, 0);
        check("after_rst_fifo_count", i, fifo_count, 0);
      end
    end
    words[0] = 4'($urandom);
    run_stream(1);

    // Two stop bits: 112-cycle frame, frame_done only in its last cycle.
    in_data2  = 4'b1111;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    in_data2  = 4'($urandom);
    check("sb2_fifo_count", 0, fifo_count2, 1);
    tick();
    check("sb2_tx_latency", 1, tx2, 1);
    for (int t = 0; t < FL2; t++) begin
      tick();
      check("sb2_tx", t, tx2, exp_tx(t, FL2, 4'b1111));
      check("sb2_busy", t, busy2, 1);
      check("sb2_bit_strobe", t, bit_strobe2, (t % CPB) == 0);
      check("sb2_frame_done", t, frame_done2, t == FL2 - 1);
    end
    tick();
    check("sb2_end_tx", 0, tx2, 1);
    check("sb2_end_busy", 0, busy2, 0);
    check("sb2_end_frame_done", 0, frame_done2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
